// File: rtl/daq_arb.sv
// daq_arb: round-robin arbiter that hands a shared 32-bit output stream to one
// DAQ source at a time, for one packet per grant.
//
// Parameters
//   NDAQ            number of requesting sources (1..16)
//   TIMEOUT_CYCLES  silent ACTIVE cycles tolerated before a packet is aborted
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   daq_req         per-source packet request (level)
//   daq_grant       one-cycle grant pulse, asserted in the IDLE cycle that picks
//   daq_data_in     packed source words, source i at [32*i+31:32*i]
//   daq_valid       per-source word strobe
//   daq_end         per-source end-of-packet strobe
//   out_data        last forwarded word of the owner
//   out_valid       out_data carries a word this cycle
//   out_end         owner packet ended this cycle
//   out_abort       owner packet abandoned by the watchdog (pulse)
//   out_owner       index of current or last owner
//   busy            high while a packet is granted
//   timeout_cnt     saturating count of aborted packets
//
// Build option: define DAQ_ARB_TIMEOUT_EN to include the silence watchdog.
// Without it out_abort and timeout_cnt are tied to zero.
module daq_arb #(
  parameter int unsigned NDAQ           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NDAQ-1:0]                        daq_req,
  output logic [NDAQ-1:0]                        daq_grant,
  input  logic [32*NDAQ-1:0]                     daq_data_in,
  input  logic [NDAQ-1:0]                        daq_valid,
  input  logic [NDAQ-1:0]                        daq_end,
  output logic [31:0]                            out_data,
  output logic                                   out_valid,
  output logic                                   out_end,
  output logic                                   out_abort,
  output logic [((NDAQ > 1) ? $clog2(NDAQ) : 1)-1:0] out_owner,
  output logic                                   busy,
  output logic [15:0]                            timeout_cnt
);

  localparam int unsigned OW = (NDAQ > 1) ? $clog2(NDAQ) : 1;

  typedef enum logic {StIdle, StActive} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, last_q, pick;
  logic          found;
  logic          own_valid, own_end, expire;
  logic [31:0]   own_data;
  logic [31:0]   data_q;
  logic          valid_q, end_q;
  int unsigned   idx;

  // Rotating search starting just above the previous owner.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NDAQ; k++) begin
      idx = (32'(last_q) + k) % NDAQ;
      if (!found && daq_req[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  assign own_valid = daq_valid[owner_q];
  assign own_end   = daq_end[owner_q];
  assign own_data  = daq_data_in[32*int'(owner_q) +: 32];

  assign daq_grant = (state_q == StIdle && found) ? (NDAQ'(1) << pick) : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (found) state_d = StActive;
      StActive: if (own_end || expire) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= OW'(NDAQ - 1);
      data_q  <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && found) owner_q <= pick;
      if (state_q == StActive && (own_end || expire)) last_q <= owner_q;
      valid_q <= (state_q == StActive) && own_valid;
      end_q   <= (state_q == StActive) && own_end;
      if (state_q == StActive && own_valid) data_q <= own_data;
    end
  end

`ifdef DAQ_ARB_TIMEOUT_EN
  localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [WW-1:0] wd_q;
  logic          abort_q;
  logic [15:0]   tcnt_q;

  // Expiry only on a silent cycle, so an end on the final cycle always wins.
  assign expire = (state_q == StActive) && !own_valid && !own_end &&
                  (wd_q == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q    <= '0;
      abort_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      if (state_q != StActive || own_valid || own_end || expire) wd_q <= '0;
      else wd_q <= wd_q + 1'b1;
      abort_q <= expire;
      if (expire && tcnt_q != 16'hffff) tcnt_q <= tcnt_q + 16'd1;
    end
  end

  assign out_abort   = abort_q;
  assign timeout_cnt = tcnt_q;
`else
  assign expire      = 1'b0;
  assign out_abort   = 1'b0;
  assign timeout_cnt = 16'h0000;
`endif

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_end   = end_q;
  assign out_owner = owner_q;
  assign busy      = (state_q == StActive);

endmodule

// File: tb/tb_daq_arb.sv
// Self-checking bench for daq_arb (NDAQ=4, TIMEOUT_CYCLES=8): directed steps
// followed by random traffic, compared against a packet-level reference model.
module tb_daq_arb;

  localparam int N = 4;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   daq_req = '0, daq_valid = '0, daq_end = '0;
  logic [3:0]   daq_grant;
  logic [127:0] daq_data_in = '0;
  logic [31:0]  out_data;
  logic         out_valid, out_end, out_abort, busy;
  logic [1:0]   out_owner;
  logic [15:0]  timeout_cnt;

  daq_arb #(.NDAQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .daq_req    (daq_req),
    .daq_grant  (daq_grant),
    .daq_data_in(daq_data_in),
    .daq_valid  (daq_valid),
    .daq_end    (daq_end),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_end    (out_end),
    .out_abort  (out_abort),
    .out_owner  (out_owner),
    .busy       (busy),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

`ifdef DAQ_ARB_TIMEOUT_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  // Reference model: who holds the stream, who held it last, what the output
  // port should show this cycle.
  bit          m_busy, m_oval, m_oend, m_oab;
  int          m_owner, m_last, m_silent, m_tcnt;
  logic [31:0] m_odata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int next_winner(input logic [3:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_oval = 0; m_oend = 0; m_oab = 0;
    m_owner = 0; m_last = N - 1; m_silent = 0; m_tcnt = 0; m_odata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    daq_req = '0; daq_valid = '0; daq_end = '0; daq_data_in = '0;
    #1;
    chk("rst_grant", 32'(daq_grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(out_owner), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_end", 32'(out_end), 0);
    chk("rst_abort", 32'(out_abort), 0);
    chk("rst_tcnt", 32'(timeout_cnt), 0);
    chk("rst_data", out_data, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic [3:0] r, input logic [3:0] v, input logic [3:0] e,
                      input logic [127:0] d);
    int p;
    @(negedge clk);
    daq_req = r; daq_valid = v; daq_end = e; daq_data_in = d;
    #1;
    p = m_busy ? -1 : next_winner(r);
    chk("grant", 32'(daq_grant), (p < 0) ? 0 : (32'd1 << p));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("owner", 32'(out_owner), 32'(m_owner));
    chk("out_valid", 32'(out_valid), 32'(m_oval));
    chk("out_end", 32'(out_end), 32'(m_oend));
    chk("out_abort", 32'(out_abort), 32'(m_oab));
    chk("tcnt", 32'(timeout_cnt), 32'(m_tcnt));
    if (m_oval) chk("out_data", out_data, m_odata);
    m_oab = 0;
    if (!m_busy) begin
      m_oval = 0; m_oend = 0;
      if (p >= 0) begin
        m_busy = 1; m_owner = p; m_silent = 0;
      end
    end else begin
      m_oval = v[m_owner];
      m_oend = e[m_owner];
      if (v[m_owner]) m_odata = d[32*m_owner +: 32];
      if (e[m_owner]) begin
        m_busy = 0; m_last = m_owner;
      end else if (v[m_owner]) begin
        m_silent = 0;
      end else begin
        m_silent++;
        if (WdEn && m_silent == T) begin
          m_oab = 1; m_busy = 0; m_last = m_owner;
          if (m_tcnt < 65535) m_tcnt++;
        end
      end
    end
  endtask

  function automatic logic [127:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] d;
    int own, quiet;

    // Two requesters after reset: lowest index above last_owner=3 wins.
    do_reset();
    step(4'b1010, 4'b0000, 4'b0000, '0);
    chk("r31_grant", 32'(daq_grant), 32'h2);
    @(posedge clk); #1;
    chk("r31_owner", 32'(out_owner), 1);
    chk("r31_busy", 32'(busy), 1);
    step(4'b0000, 4'b0010, 4'b0000, rnd_data());
    step(4'b0000, 4'b0000, 4'b0010, '0);
    step(4'b0000, 4'b0000, 4'b0000, '0);

    // All four requesting: 3 words + end each, order 0,1,2,3,0.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      own = p % N;
      step(4'b1111, 4'b0000, 4'b0000, '0);
      chk("r32_grant", 32'(daq_grant), 32'd1 << own);
      for (int w = 0; w < 3; w++) step(4'b1111, 4'(1 << own), 4'b0000, rnd_data());
      step(4'b1111, 4'b0000, 4'(1 << own), '0);
    end
    step(4'b0000, 4'b0000, 4'b0000, '0);

    // Owner 2: valid and end together.
    do_reset();
    step(4'b0100, 4'b0000, 4'b0000, '0);
    d = rnd_data();
    d[64 +: 32] = 32'hdeadbeef;
    step(4'b0000, 4'b0100, 4'b0100, d);
    @(posedge clk); #1;
    chk("r33_valid", 32'(out_valid), 1);
    chk("r33_end", 32'(out_end), 1);
    chk("r33_data", out_data, 32'hdeadbeef);
    chk("r33_busy", 32'(busy), 0);

`ifdef DAQ_ARB_TIMEOUT_EN
    // Silent owner aborts after 8 cycles; then an end on the 8th cycle wins.
    do_reset();
    step(4'b0001, 4'b0000, 4'b0000, '0);
    for (int i = 0; i < T; i++) step(4'b0100, 4'b0000, 4'b0000, '0);
    @(posedge clk); #1;
    chk("r34_abort", 32'(out_abort), 1);
    chk("r34_tcnt", 32'(timeout_cnt), 1);
    chk("r34_next_grant", 32'(daq_grant), 32'h4);
    step(4'b0100, 4'b0000, 4'b0000, '0);
    for (int i = 0; i < T - 1; i++) step(4'b0000, 4'b0000, 4'b0000, '0);
    step(4'b0000, 4'b0000, 4'b0100, '0);
    @(posedge clk); #1;
    chk("r34_end", 32'(out_end), 1);
    chk("r34_no_abort", 32'(out_abort), 0);
    chk("r34_tcnt_kept", 32'(timeout_cnt), 1);
`endif

    // Reset in the middle of owner 3's packet.
    do_reset();
    step(4'b1000, 4'b0000, 4'b0000, '0);
    step(4'b0000, 4'b1000, 4'b0000, rnd_data());
    step(4'b0000, 4'b0000, 4'b0000, '0);
    do_reset();
    step(4'b0000, 4'b0000, 4'b1000, '0);
    step(4'b1000, 4'b0000, 4'b0000, '0);
    chk("r35_grant", 32'(daq_grant), 32'h8);
    step(4'b0000, 4'b0000, 4'b1000, '0);

    // Random traffic with occasional long silences to exercise the watchdog.
    do_reset();
    quiet = 0;
    for (int c = 0; c < 1500; c++) begin
      if (quiet == 0 && $urandom_range(0, 40) == 0) quiet = $urandom_range(5, 12);
      if (quiet > 0) begin
        quiet--;
        step(4'($urandom), 4'b0000, 4'b0000, rnd_data());
      end else begin
        step(4'($urandom), 4'($urandom), 4'($urandom & $urandom & $urandom), rnd_data());
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
